// File: rtl/reg_file_seq.sv
// Sequencing FSM for a small register-file CPU: fetch/decode/execute/memory/writeback
// control with registered Moore outputs, a bounded data-memory wait and a sticky halt.
module reg_file_seq (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic [3:0] IR_opcode,
    input  logic       cond_pass,
    input  logic [3:0] PC_in,
    input  logic       DMEM_ready,
    output logic       IR_load,
    output logic       CNTRL_write_en_ARd,
    output logic       sel_ARd_or_15,
    output logic       sel_DMEM,
    output logic [3:0] PC_next,
    output logic       DMEM_req,
    output logic       DMEM_we,
    output logic       busy,
    output logic       halted,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] wait_q, wait_d;
    logic       act_wr_q, act_wr_d;
    logic       act_br_q, act_br_d;
    logic       act_ld_q, act_ld_d;
    logic       act_st_q, act_st_d;
    logic       ir_load_q, ir_load_d;
    logic       wr_en_q, wr_en_d;
    logic       sel15_q, sel15_d;
    logic       seldm_q, seldm_d;
    logic       req_q, req_d;
    logic       we_q, we_d;
    logic       busy_q, busy_d;
    logic       halted_q, halted_d;
    logic       error_q, error_d;
    logic       inc_q, inc_d;
    logic       clr_q;
    logic       is_alu_s, is_ldr_s, is_str_s, is_b_s;

    assign is_alu_s = (IR_opcode[3] == 1'b0);
    assign is_ldr_s = (IR_opcode == 4'b1000);
    assign is_str_s = (IR_opcode == 4'b1001);
    assign is_b_s   = (IR_opcode == 4'b1010);

    // Next-state, latched instruction action and next registered outputs.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        act_wr_d = act_wr_q;
        act_br_d = act_br_q;
        act_ld_d = act_ld_q;
        act_st_d = act_st_q;
        error_d  = error_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (IR_opcode == 4'b1111) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Action is captured here so the later cycles don't depend on cond_pass.
                act_wr_d = cond_pass & (is_alu_s | is_ldr_s | is_b_s);
                act_br_d = cond_pass & is_b_s;
                act_ld_d = cond_pass & is_ldr_s;
                act_st_d = is_str_s;
                wait_d   = 5'd0;
                if (cond_pass && (is_ldr_s || is_str_s)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (DMEM_ready) begin
                    state_d = S_WB;
                end else if (wait_q == 5'd15) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 5'd1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        ir_load_d = (state_d == S_FETCH);
        wr_en_d   = (state_d == S_WB) && act_wr_d;
        sel15_d   = (state_d == S_WB) && act_br_d;
        seldm_d   = (state_d == S_WB) && act_ld_d;
        inc_d     = (state_d == S_WB) && !act_br_d;
        req_d     = (state_d == S_MEM);
        we_d      = (state_d == S_MEM) && act_st_d;
        busy_d    = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC)
                 || (state_d == S_MEM) || (state_d == S_WB);
        halted_d  = (state_d == S_HALT);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            wait_q    <= 5'd0;
            act_wr_q  <= 1'b0;
            act_br_q  <= 1'b0;
            act_ld_q  <= 1'b0;
            act_st_q  <= 1'b0;
            ir_load_q <= 1'b0;
            wr_en_q   <= 1'b0;
            sel15_q   <= 1'b0;
            seldm_q   <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            error_q   <= 1'b0;
            inc_q     <= 1'b0;
            clr_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            act_wr_q  <= act_wr_d;
            act_br_q  <= act_br_d;
            act_ld_q  <= act_ld_d;
            act_st_q  <= act_st_d;
            ir_load_q <= ir_load_d;
            wr_en_q   <= wr_en_d;
            sel15_q   <= sel15_d;
            seldm_q   <= seldm_d;
            req_q     <= req_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            error_q   <= error_d;
            inc_q     <= inc_d;
            clr_q     <= 1'b0;
        end
    end

    // PC_next is a registered-select mux over the live R15 value, so R15 never rewrites a stale copy.
    assign PC_next = clr_q ? 4'd0 : (inc_q ? (PC_in + 4'd1) : PC_in);

    assign IR_load            = ir_load_q;
    assign CNTRL_write_en_ARd = wr_en_q;
    assign sel_ARd_or_15      = sel15_q;
    assign sel_DMEM           = seldm_q;
    assign DMEM_req           = req_q;
    assign DMEM_we            = we_q;
    assign busy               = busy_q;
    assign halted             = halted_q;
    assign error              = error_q;

endmodule

// File: tb/tb_reg_file_seq.sv
// Directed bench for reg_file_seq: control vector and PC_next checked one step after each edge.
module tb_reg_file_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] opcode;
    logic       cond;
    logic [3:0] pc_in;
    logic       ready;
    logic       ir_load, wr_en, sel15, seldm, req, dwe, busy, halted, error;
    logic [3:0] pc_next;

    int n_tests = 0;
    int n_fail  = 0;

    // Control vector: {IR_load, write_en, sel_ARd_or_15, sel_DMEM, DMEM_req, DMEM_we, busy, halted, error}
    localparam logic [8:0] C_ZERO   = 9'b000000000;
    localparam logic [8:0] C_FETCH  = 9'b100000100;
    localparam logic [8:0] C_BUSY   = 9'b000000100;
    localparam logic [8:0] C_WB_ALU = 9'b010000100;
    localparam logic [8:0] C_WB_LDR = 9'b010100100;
    localparam logic [8:0] C_WB_B   = 9'b011000100;
    localparam logic [8:0] C_MEM_LD = 9'b000010100;
    localparam logic [8:0] C_MEM_ST = 9'b000011100;
    localparam logic [8:0] C_HALT   = 9'b000000010;
    localparam logic [8:0] C_HALTE  = 9'b000000011;
    localparam logic [8:0] M_ALL    = 9'b111111111;
    localparam logic [8:0] M_MEM    = 9'b110011111;
    localparam logic [8:0] M_CTL    = 9'b110010111;

    reg_file_seq dut (
        .CLOCK_50           (clk),
        .RESET              (rst),
        .START              (start),
        .IR_opcode          (opcode),
        .cond_pass          (cond),
        .PC_in              (pc_in),
        .DMEM_ready         (ready),
        .IR_load            (ir_load),
        .CNTRL_write_en_ARd (wr_en),
        .sel_ARd_or_15      (sel15),
        .sel_DMEM           (seldm),
        .PC_next            (pc_next),
        .DMEM_req           (req),
        .DMEM_we            (dwe),
        .busy               (busy),
        .halted             (halted),
        .error              (error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [8:0] mask, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {ir_load, wr_en, sel15, seldm, req, dwe, busy, halted, error};
        n_tests++;
        assert ((obs & mask) === (exp & mask)) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (mask %b)", tag, obs, exp, mask);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [3:0] exp);
        n_tests++;
        assert (pc_next === exp) else begin
            n_fail++;
            $error("FAIL %s: observed PC_next %0d expected %0d", tag, pc_next, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 4'd0; cond = 1'b0; pc_in = 4'd0; ready = 1'b0;
        step(); step();
        chk_ctl("reset_ctl", M_ALL, C_ZERO);
        pc_in = 4'd6;
        #1;
        chk_pc("reset_pc", 4'd0);
        rst = 1'b0;
        step();
        chk_ctl("idle_after_reset", M_ALL, C_ZERO);
        chk_pc("idle_pc", 4'd6);
        step();
        chk_ctl("idle_hold", M_ALL, C_ZERO);

        // ALU 0011, PC 2
        pc_in = 4'd2; opcode = 4'b0011; cond = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        chk_ctl("alu_fetch", M_CTL, C_FETCH);
        chk_pc("alu_fetch_pc", 4'd2);
        start = 1'b1;
        step(); start = 1'b0;
        chk_ctl("alu_decode", M_CTL, C_BUSY);
        step(); chk_ctl("alu_exec", M_CTL, C_BUSY);
        step(); chk_ctl("alu_wb", M_ALL, C_WB_ALU);
        chk_pc("alu_wb_pc", 4'd3);
        step(); chk_ctl("alu_refetch", M_CTL, C_FETCH);
        chk_pc("alu_refetch_pc", 4'd2);

        // LDR, ready in third MEM cycle, PC 15 wraps
        opcode = 4'b1000; pc_in = 4'd15;
        step(); chk_ctl("ldr_decode", M_CTL, C_BUSY);
        step(); chk_ctl("ldr_exec", M_CTL, C_BUSY);
        step(); chk_ctl("ldr_mem1", M_MEM, C_MEM_LD);
        step(); chk_ctl("ldr_mem2", M_MEM, C_MEM_LD);
        step(); chk_ctl("ldr_mem3", M_MEM, C_MEM_LD);
        ready = 1'b1;
        step(); ready = 1'b0;
        chk_ctl("ldr_wb", M_ALL, C_WB_LDR);
        chk_pc("ldr_wb_wrap", 4'd0);
        step(); chk_ctl("ldr_refetch", M_CTL, C_FETCH);

        // B taken
        opcode = 4'b1010; pc_in = 4'd5;
        step(); step();
        step(); chk_ctl("b_taken_wb", M_ALL, C_WB_B);
        step(); chk_ctl("b_taken_refetch", M_CTL, C_FETCH);

        // B not taken increments like a NOP
        cond = 1'b0;
        step(); step();
        step(); chk_ctl("b_nt_wb", M_ALL, C_BUSY);
        chk_pc("b_nt_pc", 4'd6);
        step();

        // STR with failed condition skips MEM
        opcode = 4'b1001; pc_in = 4'd4;
        step(); step();
        step(); chk_ctl("str_nc_wb", M_ALL, C_BUSY);
        chk_pc("str_nc_pc", 4'd5);
        step();

        // STR never acknowledged: 16 MEM cycles then error halt
        cond = 1'b1; pc_in = 4'd7;
        step(); step();
        for (int i = 0; i < 16; i++) begin
            step();
            chk_ctl($sformatf("str_to_mem%0d", i), M_MEM, C_MEM_ST);
        end
        step(); chk_ctl("str_to_halt", M_ALL, C_HALTE);
        chk_pc("str_to_pc", 4'd7);
        start = 1'b1;
        step(); step(); start = 1'b0;
        chk_ctl("halt_ignores_start", M_ALL, C_HALTE);
        pc_in = 4'd9;
        #1;
        chk_pc("halt_pc_track", 4'd9);
        rst = 1'b1;
        step(); chk_ctl("halt_reset", M_ALL, C_ZERO);
        chk_pc("halt_reset_pc", 4'd0);
        rst = 1'b0;
        step(); chk_ctl("halt_reset_idle", M_ALL, C_ZERO);

        // Reset in second MEM cycle of STR
        opcode = 4'b1001; cond = 1'b1; pc_in = 4'd3; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        step(); chk_ctl("abort_mem1", M_MEM, C_MEM_ST);
        step(); chk_ctl("abort_mem2", M_MEM, C_MEM_ST);
        rst = 1'b1;
        step(); chk_ctl("abort_reset", M_ALL, C_ZERO);
        chk_pc("abort_pc", 4'd0);
        rst = 1'b0;
        step(); chk_ctl("abort_idle", M_ALL, C_ZERO);
        step(); chk_ctl("abort_stay_idle", M_ALL, C_ZERO);

        // HALT opcode
        opcode = 4'b1111; start = 1'b1;
        step(); start = 1'b0;
        chk_ctl("hlt_fetch", M_CTL, C_FETCH);
        step(); chk_ctl("hlt_decode", M_CTL, C_BUSY);
        step(); chk_ctl("hlt_halt", M_ALL, C_HALT);
        for (int i = 0; i < 10; i++) begin
            pc_in = 4'(i + 5);
            step();
            chk_ctl($sformatf("hlt_hold%0d", i), M_ALL, C_HALT);
            chk_pc($sformatf("hlt_pc%0d", i), 4'(i + 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
